// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional build macro MEM_ARB_RR_EN switches conflict resolution to round-robin.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StResp
  } arb_state_e;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_DMA = 1;

  localparam int unsigned DEF_AW        = 32;
  localparam int unsigned DEF_DW        = 32;
  localparam int unsigned DEF_MAX_BURST = 8;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection: lock override, then fixed priority or round-robin on conflict.
// Round-robin is built when MEM_ARB_RR_EN is defined; otherwise port 0 wins conflicts.
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_win_i,
  input  logic       lock1_i,
  input  logic       burst_sat_i,
`ifdef MEM_ARB_RR_EN
  input  logic       rr_last_i,
`endif
  output logic [1:0] sel_o,
  output logic       locked_o
);

  logic lock_hold;

  assign lock_hold = last_win_i & lock1_i & req_i[PORT_DMA] & ~burst_sat_i;
  assign locked_o  = lock_hold;

  always_comb begin
    sel_o = '0;
    if (lock_hold) begin
      sel_o = port_onehot(1'b1);
    end else if (&req_i) begin
`ifdef MEM_ARB_RR_EN
      // The port that did not win last time takes the conflict.
      sel_o = port_onehot(~rr_last_i);
`else
      sel_o = port_onehot(1'b0);
`endif
    end else begin
      sel_o = req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one access per two cycles, burst lock for port 1.
// Define MEM_ARB_RR_EN for round-robin conflict resolution (default fixed priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  input  logic            lock1,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BurstMax = BW'(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic          last_win_q, last_win_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
`ifdef MEM_ARB_RR_EN
  logic          rr_last_q, rr_last_d;
`endif

  logic [1:0] sel;
  logic       locked;
  logic       burst_sat;
  logic       win;

  assign burst_sat = (burst_cnt_q >= BurstMax);
  assign win       = sel[PORT_DMA];

  mem_arb_prio u_prio (
    .req_i       (req),
    .last_win_i  (last_win_q),
    .lock1_i     (lock1),
    .burst_sat_i (burst_sat),
`ifdef MEM_ARB_RR_EN
    .rr_last_i   (rr_last_q),
`endif
    .sel_o       (sel),
    .locked_o    (locked)
  );

  always_comb begin
    state_d     = state_q;
    last_win_d  = last_win_q;
    burst_cnt_d = burst_cnt_q;
`ifdef MEM_ARB_RR_EN
    rr_last_d   = rr_last_q;
`endif
    gnt       = '0;
    rvalid    = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    mem_addr  = win ? addr[2*AW-1:AW] : addr[AW-1:0];
    mem_wdata = win ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    rdata     = mem_rdata;

    // Strobes stay low for the whole reset cycle regardless of state.
    if (reset) begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            gnt        = sel;
            mem_en     = 1'b1;
            mem_we     = we[win];
            last_win_d = win;
            state_d    = StResp;
          end
        end
        StResp: begin
          rvalid  = port_onehot(last_win_q);
          busy    = 1'b1;
          state_d = StIdle;
        end
      endcase
    end

    if (!lock1 || gnt[PORT_CPU]) begin
      burst_cnt_d = '0;
    end else if (gnt[PORT_DMA] && locked) begin
      burst_cnt_d = burst_cnt_q + BW'(1);
    end

`ifdef MEM_ARB_RR_EN
    if (|gnt) begin
      rr_last_d = win;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_win_q  <= 1'(PORT_CPU);
      burst_cnt_q <= '0;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      last_win_q  <= last_win_d;
      burst_cnt_q <= burst_cnt_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses, conflicts, burst lock and reset abort.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      req = '0;
  logic [1:0]      we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic            lock1 = 1'b0;
  logic [1:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_en, mem_we, busy;
  logic [AW-1:0]   mem_addr;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .lock1     (lock1),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[11:2]];
    end
  end

  typedef struct {
    logic        port;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } gnt_exp_t;

  typedef struct {
    logic        port;
    bit          chk;
    logic [31:0] d;
  } rsp_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];
  gnt_exp_t ge;
  rsp_exp_t re;
  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every grant and response against the queued expectations.
  always @(negedge clk) begin
    if (mem_we) wr_pulses++;
    if (gnt != 2'b00) begin
      if (gq.size() == 0) begin
        check("unexpected_gnt", 64'(gnt), 64'd0);
      end else begin
        ge = gq.pop_front();
        check("gnt", 64'(gnt), 64'(port_onehot(ge.port)));
        check("mem_en", 64'(mem_en), 64'd1);
        check("mem_we", 64'(mem_we), 64'(ge.w));
        check("mem_addr", 64'(mem_addr), 64'(ge.a));
        if (ge.w) check("mem_wdata", 64'(mem_wdata), 64'(ge.d));
      end
    end
    if (rvalid != 2'b00) begin
      if (rq.size() == 0) begin
        check("unexpected_rvalid", 64'(rvalid), 64'd0);
      end else begin
        re = rq.pop_front();
        check("rvalid", 64'(rvalid), 64'(port_onehot(re.port)));
        if (re.chk) check("rdata", 64'(rdata), 64'(re.d));
      end
    end
  end

  task automatic expect_acc(input logic p, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input bit rsp, input logic [31:0] rd);
    gnt_exp_t g;
    rsp_exp_t r;
    g.port = p; g.w = w; g.a = a; g.d = d;
    gq.push_back(g);
    if (rsp) begin
      r.port = p; r.chk = !w; r.d = rd;
      rq.push_back(r);
    end
  endtask

  // Issue one access; returns at the start of the response cycle with req dropped.
  task automatic access(input logic p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit rsp, input logic [31:0] rd);
    bit granted;
    granted = 0;
    expect_acc(p, w, a, d, rsp, rd);
    req[p] = 1'b1;
    we[p]  = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (gnt[p]) begin
        granted = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!granted) begin
      errors++;
      $display("FAIL grant_timeout: port %0d got no grant, required one within 16 cycles", p);
    end else begin
      @(posedge clk); #1;
    end
    req[p] = 1'b0;
    we[p]  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[16] = 32'hDEADBEEF;

    // Reset: outputs forced low even with requests pending.
    reset = 1'b0; req = 2'b11; we = 2'b11; lock1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    req = '0; we = '0; lock1 = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("idle_gnt", 64'(gnt), 64'd0);
    check("idle_mem_en", 64'(mem_en), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    idle(1);

    // Single read, then a withdrawn port-1 write during the response cycle.
    access(1'b0, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF);
    req[1] = 1'b1; we[1] = 1'b1; addr[AW +: AW] = 32'h40; wdata[DW +: DW] = 32'h0;
    @(negedge clk);
    check("rd_latency_rvalid", 64'(rvalid), 64'h1);
    check("rd_latency_rdata", 64'(rdata), 64'hDEADBEEF);
    check("withdraw_gnt", 64'(gnt), 64'd0);
    check("resp_busy", 64'(busy), 64'd1);
    req = '0; we = '0;
    idle(2);

    // Write from port 1, read back from port 0, then port-1 read.
    access(1'b1, 1'b1, 32'h100, 32'h12345678, 1, 32'h0);
    idle(2);
    access(1'b0, 1'b0, 32'h100, 32'h0, 1, 32'h12345678);
    idle(2);
    access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF);
    idle(2);

    // Conflict held for 8 cycles.
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      if (i % 2 == 1) expect_acc(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h12345678);
      else            expect_acc(1'b0, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF);
`else
      expect_acc(1'b0, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF);
`endif
    end
    addr = {32'h100, 32'h40}; we = '0; req = 2'b11;
    idle(8);
    req = '0;
    idle(2);

    // Burst: initial port-1 grant, four locked grants, then port 0.
    for (int i = 0; i < 5; i++) expect_acc(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h12345678);
    expect_acc(1'b0, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF);
    lock1 = 1'b1; addr = {32'h100, 32'h40}; req = 2'b10;
    idle(1);
    req = 2'b11;
    idle(10);
    req = '0;
    check("burst_cnt_cleared", 64'(dut.burst_cnt_q), 64'd0);
    lock1 = 1'b0;
    idle(2);

    // Reset during the response cycle aborts the response.
    access(1'b0, 1'b0, 32'h40, 32'h0, 0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_rvalid", 64'(rvalid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    expect_acc(1'b0, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF);
    addr[AW-1:0] = 32'h40; req = 2'b01;
    @(negedge clk);
    check("post_reset_gnt", 64'(gnt), 64'h1);
    check("post_reset_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    check("post_reset_rvalid", 64'(rvalid), 64'h1);
    idle(3);

    check("write_pulses", 64'(wr_pulses), 64'd1);
    check("gnt_queue_empty", 64'(gq.size()), 64'd0);
    check("rsp_queue_empty", 64'(rq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width in bits.
REQ-002 Parameter DW, default 32: data width in bits.
REQ-003 Parameter MAX_BURST, default 8: maximum consecutive locked grants to port 1 while port 0 is waiting.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req  input  2  access request per port; bit 0 is the CPU (multicycle core), bit 1 is the loader/DMA port.
REQ-007 we  input  2  write enable per port; qualified by req.
REQ-008 addr  input  2xAW  address per port.
REQ-009 wdata  input  2xDW  write data per port.
REQ-010 lock1  input  1  port 1 requests to keep ownership for a burst.
REQ-011 gnt  output  2  one-hot, single-cycle grant; winner's access is issued this cycle.
REQ-012 rvalid  output  2  one-hot; read data valid for the port granted in the previous cycle.
REQ-013 rdata  output  DW  shared read data; meaningful only when an rvalid bit is high.
REQ-014 mem_en, mem_we  output  1 each  memory access strobe and write strobe.
REQ-015 mem_addr, mem_wdata  output  AW, DW  memory address and write data.
REQ-016 mem_rdata  input  DW  memory read data; valid one cycle after mem_en (synchronous read).
REQ-017 busy  output  1  high while a response cycle is in progress.

Function
REQ-018 The FSM SHALL have two states, IDLE and RESP; IDLE->RESP on any grant, RESP->IDLE unconditionally.
REQ-019 In IDLE with req!=0, exactly one gnt bit SHALL assert in the same cycle, and mem_en, mem_we, mem_addr and mem_wdata SHALL carry the winner's we/addr/wdata combinationally.
REQ-020 In IDLE with req==0: gnt=0 and mem_en=0, and the state SHALL remain IDLE.
REQ-021 In RESP, rvalid[w]=1 for the previous winner w, and rdata=mem_rdata; rvalid SHALL also pulse for writes, acting as an acknowledge.
REQ-022 Throughput SHALL be one access per two cycles; no grant SHALL be issued in RESP.
REQ-023 Requesters SHALL hold req/we/addr/wdata stable until gnt; a request deasserted before gnt is withdrawn with no side effect.
REQ-024 Lock: if the previous winner was port 1, lock1=1, req[1]=1 and burst_cnt<MAX_BURST, then port 1 SHALL win regardless of priority.
REQ-025 burst_cnt SHALL increment on each locked port-1 grant, saturate at MAX_BURST, and clear on any port-0 grant or when lock1=0.
REQ-026 When burst_cnt==MAX_BURST and req[0]=1, port 0 SHALL win the next arbitration.
REQ-027 With no lock override, port 0 SHALL win on conflict (baseline fixed priority; see REQ-032).

Reset
REQ-028 While reset=0: gnt, rvalid, mem_en, mem_we and busy SHALL be forced to 0 combinationally.
REQ-029 At the first rising edge with reset=0, the state SHALL go to IDLE, burst_cnt to 0 and rr_last to 1.
REQ-030 Reset asserted in RESP SHALL abort the response: no rvalid SHALL appear after reset is released.
REQ-031 rdata after reset SHALL be don't-care.

Configuration
REQ-032 With macro MEM_ARB_RR_EN defined, conflicts SHALL be resolved round-robin: the port not equal to rr_last wins, and rr_last updates on every grant. Without the macro, port 0 SHALL always win conflicts and rr_last SHALL not exist.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state enum typedef, PORT_CPU=0 and PORT_DMA=1 constants, and default parameter values.
REQ-034 Winner selection (priority, round-robin and lock override) SHALL be a sub-module mem_arb_prio; the FSM, counters and muxing stay in mem_arbiter.

Verification
REQ-035 Single read: req=01, addr0=0x40, memory[0x40]=0xDEADBEEF -> gnt=01 in cycle 0, then rvalid=01 and rdata=0xDEADBEEF in cycle 1.
REQ-036 Write then read: port 1 writes 0x12345678 to 0x100 -> single mem_we pulse with those values; a following port-0 read of 0x100 returns 0x12345678.
REQ-037 Conflict: req=11 held for 8 cycles -> without macro, grants 0,0,0,0; with MEM_ARB_RR_EN, grants 0,1,0,1.
REQ-038 Burst: MAX_BURST=4, lock1=1, req=11 continuously after an initial port-1 grant -> 4 locked port-1 grants, then port 0 granted and burst_cnt=0.
REQ-039 Reset asserted during RESP for 1 cycle -> rvalid=0, state IDLE, burst_cnt=0; the next req=01 is granted the cycle after reset is released.
